// File: rtl/felis_fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
//   fetch_state_t : fetch FSM encoding (IDLE, REQ, DONE, DRAIN)
//   INST_BYTES    : bytes per instruction word
//   word_align()  : clears the byte-offset bits of an address
package felis_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int INST_BYTES = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(32'(INST_BYTES) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// One-entry instruction line buffer: tag (word address), data word, valid bit.
// Only built when FELIS_FETCH_CACHE_EN is defined.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (invalidates the entry)
//   lookup_tag  : word address being looked up (pc[31:2])
//   hit         : entry valid and tag matches lookup_tag
//   hit_word    : stored data word
//   fill_en     : write tag/word and mark the entry valid
//   fill_tag    : tag to store
//   fill_word   : data word to store
module fetch_line_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] lookup_tag,
    output logic        hit,
    output logic [31:0] hit_word,
    input  logic        fill_en,
    input  logic [29:0] fill_tag,
    input  logic [31:0] fill_word
);

    logic        valid_q;
    logic [29:0] tag_q;
    logic [31:0] word_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
            word_q  <= fill_word;
        end
    end

    assign hit      = valid_q && (tag_q == lookup_tag);
    assign hit_word = word_q;

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch unit serving the core controller's fetch request.
// While fetcher_reset=1 the unit idles; when it drops, the word at pc is read
// from instruction memory, registered on instruction, and fetcher_completed
// is raised until fetcher_reset returns high.
// Optional feature: define FELIS_FETCH_CACHE_EN to add a one-entry line buffer
// that answers a repeated fetch of the same word without a memory request.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   fetcher_reset     : 1 = abort/idle, 0 = fetch word at pc
//   pc                : fetch byte address (bits [1:0] ignored), sampled in IDLE only
//   fetcher_completed : 1 while instruction holds the requested word (state DONE)
//   instruction       : fetched word, registered
//   mem_addr          : registered word address of the request
//   mem_valid         : read request valid
//   mem_data          : read data, valid in the handshake cycle
//   mem_ready         : memory accepts request / data present
//   fetch_state_dbg   : current FSM state (debug)
// Memory channel: a transfer happens in any cycle where mem_valid && mem_ready.
// Once raised, mem_valid stays high until that transfer (or reset); mem_addr is
// held constant for the whole request.
module instruction_fetcher
    import felis_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_INSTRUCTION = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetcher_reset,
    input  logic [31:0] pc,
    output logic        fetcher_completed,
    output logic [31:0] instruction,
    output logic [31:0] mem_addr,
    output logic        mem_valid,
    input  logic [31:0] mem_data,
    input  logic        mem_ready,
    output logic [1:0]  fetch_state_dbg
);

    fetch_state_t state, next_state;

    logic        handshake;
    logic        start;
    logic        capture;
    logic        hit_capture;
    logic        cache_hit;
    logic [31:0] cache_word;

    assign handshake = mem_valid && mem_ready;
    assign start     = (state == IDLE) && !fetcher_reset;
    // Only a completed, non-aborted request produces a new instruction.
    assign capture   = (state == REQ) && handshake && !fetcher_reset;

`ifdef FELIS_FETCH_CACHE_EN
    fetch_line_buffer u_line_buffer (
        .clk        (clk),
        .reset      (reset),
        .lookup_tag (pc[31:2]),
        .hit        (cache_hit),
        .hit_word   (cache_word),
        .fill_en    (capture),
        .fill_tag   (mem_addr[31:2]),
        .fill_word  (mem_data)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_word = '0;
`endif

    assign hit_capture = start && cache_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state        = state;
        mem_valid         = 1'b0;
        fetcher_completed = 1'b0;
        case (state)
            IDLE: begin
                if (!fetcher_reset) begin
                    next_state = cache_hit ? DONE : REQ;
                end
            end
            REQ: begin
                mem_valid = 1'b1;
                if (fetcher_reset) begin
                    // Data arriving together with the abort is simply dropped.
                    next_state = handshake ? IDLE : DRAIN;
                end else if (handshake) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                fetcher_completed = 1'b1;
                if (fetcher_reset) begin
                    next_state = IDLE;
                end
            end
            DRAIN: begin
                // The request cannot be withdrawn; wait for it to finish and
                // return to IDLE regardless of fetcher_reset.
                mem_valid = 1'b1;
                if (handshake) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr    <= '0;
            instruction <= RESET_INSTRUCTION;
        end else begin
            if (start) begin
                mem_addr <= word_align(pc);
            end
            if (capture) begin
                instruction <= mem_data;
            end else if (hit_capture) begin
                instruction <= cache_word;
            end
        end
    end

    assign fetch_state_dbg = state;

endmodule
